// File: rtl/alu_fpga_pkg.sv
// Board-level ALU exerciser: sequencer states and key indices.
package alu_fpga_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam int unsigned NKEY        = 3;
    localparam int unsigned KEY_ENTER   = 0;
    localparam int unsigned KEY_PAGE    = 1;
    localparam int unsigned KEY_RESTART = 2;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: ALU opcode encoding.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SLL = 4'h5,
        ALU_SRL = 4'h6
    } aluop_t;

endpackage

// File: rtl/alu_if.sv
// Connection bundle between an ALU and its user.
interface alu_if #(
    parameter int unsigned W = 32
) ();
    import cpu_types_pkg::*;

    logic [W-1:0] porta;
    logic [W-1:0] portb;
    aluop_t       aluop;
    logic [W-1:0] res;
    logic         neg;
    logic         zero;
    logic         ovf;

    modport alu  (input  porta, portb, aluop, output res, neg, zero, ovf);
    modport user (output porta, portb, aluop, input  res, neg, zero, ovf);
endinterface

// File: rtl/alu.sv
// Combinational ALU with negative/zero/signed-overflow flags; undefined opcodes give 0.
module alu
    import cpu_types_pkg::*;
#(
    parameter int unsigned W = 32
) (
    alu_if.alu aif
);
    localparam int unsigned SH_W = $clog2(W);

    logic [W-1:0] r;
    logic         ovf;

    // Operation select and overflow detection
    always_comb begin
        r   = '0;
        ovf = 1'b0;
        case (aif.aluop)
            ALU_ADD: begin
                r   = aif.porta + aif.portb;
                ovf = (aif.porta[W-1] == aif.portb[W-1]) && (r[W-1] != aif.porta[W-1]);
            end
            ALU_SUB: begin
                r   = aif.porta - aif.portb;
                ovf = (aif.porta[W-1] != aif.portb[W-1]) && (r[W-1] != aif.porta[W-1]);
            end
            ALU_AND: r = aif.porta & aif.portb;
            ALU_OR:  r = aif.porta | aif.portb;
            ALU_XOR: r = aif.porta ^ aif.portb;
            ALU_SLL: r = aif.porta << aif.portb[SH_W-1:0];
            ALU_SRL: r = aif.porta >> aif.portb[SH_W-1:0];
            default: r = '0;
        endcase
    end

    assign aif.res  = r;
    assign aif.neg  = r[W-1];
    assign aif.zero = (r == '0);
    assign aif.ovf  = ovf;
endmodule

// File: rtl/key_debounce.sv
// Active-low key: 2-FF synchroniser, counter debounce, one-cycle press pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // Accept a level only after it differs from the stable value for DEBOUNCE_CYC cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n};
            press  <= 1'b0;
            if (sync_q[1] != stable_q) begin
                if (cnt_q == CNT_MAX) begin
                    stable_q <= sync_q[1];
                    cnt_q    <= '0;
                    press    <= ~sync_q[1];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end
endmodule

// File: rtl/alu_fpga_seq.sv
// Board-level ALU exerciser: chunked operand entry, one-cycle execute, paged result display.
// Optional feature macro: ALU_FPGA_FLAGS_EN (flag capture shown on ledg_o[7:5]).
module alu_fpga_seq
    import cpu_types_pkg::*;
    import alu_fpga_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned CHUNK_W      = 16,
    parameter int unsigned SW_W         = 18,
    parameter int unsigned LED_W        = 18,
    parameter int unsigned DEBOUNCE_CYC = 250000
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [SW_W-1:0]  sw_i,
    input  logic [2:0]       key_i,
    output logic [LED_W-1:0] ledr_o,
    output logic [7:0]       ledg_o
);
    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned PG_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [PG_W-1:0] LAST_CHUNK = PG_W'(NCHUNK - 1);

    logic [SW_W-1:0]   sw_m, sw_s;
    logic [NKEY-1:0]   press;
    logic              enter, page, restart;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    aluop_t            op_q, op_d;
    logic [PG_W-1:0]   chunk_q, chunk_d, page_q, page_d;
    logic [LED_W-1:0]  ledr_d;
    logic [7:0]        ledg_d;
    logic [2:0]        flags_q, flags_d;

    alu_if #(.W(DATA_W)) aif ();
    alu #(.W(DATA_W)) u_alu (.aif(aif));

    assign aif.porta = opa_q;
    assign aif.portb = opb_q;
    assign aif.aluop = op_q;

    // Switch synchroniser
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw_i;
            sw_s <= sw_m;
        end
    end

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk   (CLK),
            .rst_n (nRST),
            .key_n (key_i[k]),
            .press (press[k])
        );
    end

    assign enter   = press[KEY_ENTER];
    assign page    = press[KEY_PAGE];
    assign restart = press[KEY_RESTART];

    // Next-state, datapath and display decode
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        chunk_d  = chunk_q;
        page_d   = page_q;
        result_d = result_q;
        flags_d  = flags_q;
        ledr_d   = ledr_o;
        ledg_d   = '0;

        case (state_q)
            LOAD_A, LOAD_B: begin
                if (enter) begin
                    if (state_q == LOAD_A) opa_d[chunk_q*CHUNK_W +: CHUNK_W] = sw_s[CHUNK_W-1:0];
                    else                   opb_d[chunk_q*CHUNK_W +: CHUNK_W] = sw_s[CHUNK_W-1:0];
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_d = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : LOAD_OP;
                    end else begin
                        chunk_d = chunk_q + PG_W'(1);
                    end
                end
            end
            LOAD_OP: begin
                if (enter) begin
                    op_d    = aluop_t'(sw_s[3:0]);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = aif.res;
                flags_d  = {aif.neg, aif.zero, aif.ovf};
                page_d   = '0;
                state_d  = SHOW;
            end
            SHOW: begin
                if (enter) begin
                    opa_d   = '0;
                    opb_d   = '0;
                    op_d    = ALU_ADD;
                    chunk_d = '0;
                    state_d = LOAD_A;
                end else if (page) begin
                    page_d = (page_q == LAST_CHUNK) ? '0 : page_q + PG_W'(1);
                end
            end
            default: state_d = LOAD_A;
        endcase

        if (restart) begin
            opa_d   = '0;
            opb_d   = '0;
            op_d    = ALU_ADD;
            chunk_d = '0;
            page_d  = '0;
            flags_d = '0;
            state_d = LOAD_A;
        end

        case (state_q)
            LOAD_A, LOAD_B, LOAD_OP: begin
                ledr_d = '0;
                ledr_d[CHUNK_W-1:0]    = sw_s[CHUNK_W-1:0];
                ledr_d[CHUNK_W +: PG_W] = chunk_q;
            end
            SHOW: begin
                ledr_d = '0;
                ledr_d[CHUNK_W-1:0]    = result_q[page_q*CHUNK_W +: CHUNK_W];
                ledr_d[CHUNK_W +: PG_W] = page_q;
            end
            default: ledr_d = ledr_o;
        endcase

        ledg_d[4:0] = 5'(1) << state_d;
`ifdef ALU_FPGA_FLAGS_EN
        if (state_d == SHOW) ledg_d[7:5] = flags_d;
`endif
    end

    // Sequencer and output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= LOAD_A;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= ALU_ADD;
            chunk_q  <= '0;
            page_q   <= '0;
            result_q <= '0;
            ledr_o   <= '0;
            ledg_o   <= 8'h01;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            chunk_q  <= chunk_d;
            page_q   <= page_d;
            result_q <= result_d;
            ledr_o   <= ledr_d;
            ledg_o   <= ledg_d;
        end
    end

`ifdef ALU_FPGA_FLAGS_EN
    // Captured ALU flags
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) flags_q <= '0;
        else       flags_q <= flags_d;
    end
`else
    assign flags_q = '0;
    logic unused_flags;
    assign unused_flags = ^{aif.neg, aif.zero, aif.ovf, flags_d};
`endif

    logic unused_sw;
    assign unused_sw = ^sw_s;
endmodule

// File: tb/tb_alu_fpga_seq.sv
// Scoreboard bench for alu_fpga_seq: reference model predicts every LED change.
module tb_alu_fpga_seq;
    localparam int DEB = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [17:0] sw_i;
    logic [2:0]  key_i;
    logic [17:0] ledr_o;
    logic [7:0]  ledg_o;

    alu_fpga_seq #(
        .DATA_W(32), .CHUNK_W(16), .SW_W(18), .LED_W(18), .DEBOUNCE_CYC(DEB)
    ) dut (
        .CLK(CLK), .nRST(nRST), .sw_i(sw_i), .key_i(key_i), .ledr_o(ledr_o), .ledg_o(ledg_o)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [25:0] exp_q[$];
    string       name_q[$];
    logic [25:0] last_exp;
    logic        mon_en = 1'b0;

    // reference model state (0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 EXEC, 4 SHOW)
    int          mst;
    logic [31:0] m_opa, m_opb, m_res;
    int          m_op, m_chunk, m_page;
    logic [2:0]  m_flags;
    logic [17:0] m_sw;

    function automatic logic [17:0] echo(input int c, input logic [17:0] s);
        return (18'(c) << 16) | 18'(s[15:0]);
    endfunction

    function automatic logic [17:0] showv();
        logic [31:0] sh;
        sh = m_res >> (16 * m_page);
        return (18'(m_page) << 16) | 18'(sh[15:0]);
    endfunction

    function automatic logic [7:0] gval(input int st);
        logic [7:0] v;
        v = 8'(1 << st);
`ifdef ALU_FPGA_FLAGS_EN
        if (st == 4) v = v | {m_flags, 5'b0};
`endif
        return v;
    endfunction

    task automatic emit(input logic [17:0] r, input logic [7:0] g, input string nm);
        if ({r, g} != last_exp) begin
            exp_q.push_back({r, g});
            name_q.push_back(nm);
            last_exp = {r, g};
        end
    endtask

    task automatic ref_alu();
        longint sa, sb, s;
        logic   ovf;
        sa = longint'($signed(m_opa));
        sb = longint'($signed(m_opb));
        ovf = 1'b0;
        case (m_op)
            0: begin s = sa + sb; m_res = 32'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            1: begin s = sa - sb; m_res = 32'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            2: m_res = m_opa & m_opb;
            3: m_res = m_opa | m_opb;
            4: m_res = m_opa ^ m_opb;
            5: m_res = m_opa << (m_opb % 32);
            6: m_res = m_opa >> (m_opb % 32);
            default: m_res = 32'h0;
        endcase
        m_flags = {m_res[31], m_res == 32'h0, ovf};
    endtask

    task automatic model_reset();
        mst = 0; m_opa = 0; m_opb = 0; m_op = 0; m_chunk = 0; m_page = 0; m_res = 0; m_flags = 0;
    endtask

    // apply one set of simultaneous accepted key pulses ([0] enter, [1] page, [2] restart)
    task automatic model_keys(input logic [2:0] m, input string nm);
        logic [17:0] cur;
        cur = last_exp[25:8];
        if (m[2]) begin
            m_opa = 0; m_opb = 0; m_op = 0; m_chunk = 0; m_page = 0; m_flags = 0; mst = 0;
            emit(cur, gval(0), {nm, "_state"});
            emit(echo(0, m_sw), gval(0), {nm, "_echo"});
        end else if (m[0] && (mst == 0 || mst == 1)) begin
            if (mst == 0) m_opa[m_chunk*16 +: 16] = m_sw[15:0];
            else          m_opb[m_chunk*16 +: 16] = m_sw[15:0];
            if (m_chunk == 1) begin m_chunk = 0; mst = mst + 1; end
            else m_chunk = m_chunk + 1;
            emit(cur, gval(mst), {nm, "_state"});
            emit(echo(m_chunk, m_sw), gval(mst), {nm, "_echo"});
        end else if (m[0] && mst == 2) begin
            m_op = int'(m_sw[3:0]);
            ref_alu();
            m_page = 0;
            emit(cur, gval(3), {nm, "_exec"});
            mst = 4;
            emit(cur, gval(4), {nm, "_show"});
            emit(showv(), gval(4), {nm, "_page0"});
        end else if (m[0] && mst == 4) begin
            m_opa = 0; m_opb = 0; m_op = 0; m_chunk = 0; mst = 0;
            emit(cur, gval(0), {nm, "_state"});
            emit(echo(0, m_sw), gval(0), {nm, "_echo"});
        end else if (m[1] && mst == 4) begin
            m_page = (m_page == 1) ? 0 : m_page + 1;
            emit(showv(), gval(4), {nm, "_page"});
        end
    endtask

    task automatic drained(input string nm);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_change pending=%0d required=%h", nm, exp_q.size(), exp_q[0]);
            exp_q.delete();
            name_q.delete();
        end
    endtask

    task automatic set_sw(input logic [17:0] v, input string nm);
        m_sw = v;
        if (mst <= 2) emit(echo(m_chunk, v), gval(mst), {nm, "_sw"});
        @(negedge CLK);
        sw_i = v;
        repeat (6) @(negedge CLK);
        drained(nm);
    endtask

    task automatic press(input logic [2:0] m, input int hold, input string nm);
        if (hold >= DEB) model_keys(m, nm);
        @(negedge CLK);
        key_i = ~m;
        repeat (hold) @(negedge CLK);
        key_i = 3'b111;
        repeat (16) @(negedge CLK);
        drained(nm);
    endtask

    task automatic load_word(input logic [31:0] v, input string nm);
        for (int c = 0; c < 2; c++) begin
            set_sw({2'($urandom), v[c*16 +: 16]}, nm);
            press(3'b001, 8, nm);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input string nm);
        load_word(a, {nm, "_a"});
        load_word(b, {nm, "_b"});
        set_sw({2'($urandom), 12'($urandom), op}, {nm, "_op"});
        press(3'b001, 8, {nm, "_op"});
    endtask

    // monitor: every output change pops and compares one scoreboard entry
    initial begin : monitor
        logic [25:0] prev, cur, e;
        string       n;
        wait (mon_en);
        prev = {18'h0, 8'h01};
        forever begin
            @(negedge CLK);
            cur = {ledr_o, ledg_o};
            if (cur != prev) begin
                prev = cur;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change actual=%h", cur);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL %s actual=%h required=%h", n, cur, e);
                    end
                end
            end
        end
    end

    initial begin : stim
        nRST = 1'b0;
        sw_i = '0;
        key_i = 3'b111;
        m_sw = '0;
        model_reset();
        last_exp = {18'h0, 8'h01};
        repeat (3) @(negedge CLK);
        checks++;
        if (ledr_o !== 18'h0 || ledg_o !== 8'h01) begin
            errors++;
            $display("FAIL reset_init actual=%h/%h required=0/01", ledr_o, ledg_o);
        end
        mon_en = 1'b1;
        nRST = 1'b1;
        repeat (4) @(negedge CLK);

        // directed ADD with paging, wrap and ENTER+PAGE
        run_op(32'h0001_0002, 32'h0000_0003, 4'h0, "add");
        press(3'b010, 8, "add_page1");
        press(3'b010, 8, "add_wrap");
        press(3'b011, 8, "enter_page");

        // bounce rejection then one accepted chunk
        set_sw(18'h0_0005, "bnc");
        press(3'b001, 3, "bounce_short");
        press(3'b001, 6, "bounce_long");
        set_sw(18'h0_0000, "a_hi");
        press(3'b001, 8, "a_hi");

        // RESTART after one B chunk, then RESTART+ENTER
        set_sw(18'h0_0005, "b_lo");
        press(3'b001, 8, "b_lo");
        press(3'b100, 8, "restart_b");
        press(3'b101, 8, "restart_enter");

        // flags: zero, then overflow + negative
        run_op(32'h5, 32'h5, 4'h1, "sub_zero");
        press(3'b001, 8, "back");
        run_op(32'h7FFF_FFFF, 32'h1, 4'h0, "ovf");
        press(3'b010, 8, "ovf_page1");

        // asynchronous reset in SHOW
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        model_reset();
        emit(18'h0, 8'h01, "midreset");
        #1;
        checks++;
        if (ledr_o !== 18'h0 || ledg_o !== 8'h01) begin
            errors++;
            $display("FAIL midreset_async actual=%h/%h required=0/01", ledr_o, ledg_o);
        end
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        emit(echo(0, m_sw), gval(0), "post_reset_echo");
        repeat (6) @(negedge CLK);
        drained("midreset");

        // randomized transactions
        for (int t = 0; t < 8; t++) begin
            run_op($urandom, $urandom, 4'($urandom_range(0, 6)), "rnd");
            for (int p = 0; p < int'($urandom_range(0, 3)); p++) press(3'b010, 8, "rnd_page");
            press(($urandom_range(0, 1) == 1) ? 3'b011 : 3'b001, 8, "rnd_back");
        end

        repeat (10) @(negedge CLK);
        drained("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
